// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample type and 5-bit index bit reversal.
package fft_pkg;

  localparam int unsigned FFT_N     = 32;
  localparam int unsigned FFT_LOG2N = 5;
  localparam int unsigned FFT_WIDTH = 18;

  typedef struct packed {
    logic signed [FFT_WIDTH-1:0] re;
    logic signed [FFT_WIDTH-1:0] im;
  } cplx_t;

  function automatic logic [FFT_LOG2N-1:0] bitrev5(input logic [FFT_LOG2N-1:0] a);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < FFT_LOG2N; i++) begin
      r[i] = a[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pingpong_ram.sv
// Two-bank sample RAM: one write port, one registered read port, bank select per port.
module pingpong_ram
  import fft_pkg::*;
#(
  parameter int unsigned Width = 36
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic                 wbank_i,
  input  logic [FFT_LOG2N-1:0] waddr_i,
  input  logic [Width-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic                 rbank_i,
  input  logic [FFT_LOG2N-1:0] raddr_i,
  output logic [Width-1:0]     rdata_o
);

  logic [Width-1:0] mem_q [2*FFT_N];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[{wbank_i, waddr_i}] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[{rbank_i, raddr_i}];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bitrev_feeder32.sv
// Natural-order in, bit-reversed 32-sample frames out, via ping-pong banks.
// Define BITREV_FEEDER_CONJ_EN to conjugate the output (saturating), turning the FFT into an IFFT.
module bitrev_feeder32
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned N     = FFT_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] di_re_i,
  input  logic [WIDTH-1:0] di_im_i,
  input  logic             di_valid_i,
  output logic             di_ready_o,
  input  logic             fft_rdy_i,
  output logic [WIDTH-1:0] do_re_o,
  output logic [WIDTH-1:0] do_im_o,
  output logic             do_en_o,
  output logic             do_first_o,
  output logic             do_last_o
);

  localparam logic [FFT_LOG2N-1:0] LastIdx = FFT_LOG2N'(N - 1);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  state_e               state_q, state_d;
  logic [1:0]           full_q, full_d;
  logic                 wbank_q, wbank_d;
  logic                 rbank_q, rbank_d;
  logic [FFT_LOG2N-1:0] wcnt_q, wcnt_d;
  logic [FFT_LOG2N-1:0] rcnt_q, rcnt_d;
  logic                 en_q, first_q, last_q;
  logic                 wr_fire, rd_issue, out_vld;
  logic [2*WIDTH-1:0]   rdata;
  logic [WIDTH-1:0]     rd_re, rd_im, im_out;

  assign di_ready_o = !full_q[wbank_q] && !rst;
  assign wr_fire    = di_valid_i && di_ready_o;

  always_comb begin
    state_d  = state_q;
    full_d   = full_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    wcnt_d   = wcnt_q;
    rcnt_d   = rcnt_q;
    rd_issue = 1'b0;

    if (wr_fire) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == LastIdx) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = !wbank_q;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (full_q[rbank_q] && fft_rdy_i) begin
          rd_issue = 1'b1;
          state_d  = StRead;
        end
      end
      StRead:  rd_issue = 1'b1;
      default: state_d = StIdle;
    endcase

    // Writer never owns rbank while a frame is being read, so the clear cannot hit a set.
    if (rd_issue) begin
      rcnt_d = rcnt_q + 1'b1;
      if (rcnt_q == LastIdx) begin
        full_d[rbank_q] = 1'b0;
        rbank_d         = !rbank_q;
        state_d         = (full_q[!rbank_q] && fft_rdy_i) ? StRead : StIdle;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      full_q  <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      en_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      full_q  <= full_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      en_q    <= rd_issue;
      first_q <= rd_issue && (rcnt_q == '0);
      last_q  <= rd_issue && (rcnt_q == LastIdx);
    end
  end

  pingpong_ram #(
    .Width (2 * WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_fire),
    .wbank_i (wbank_q),
    .waddr_i (wcnt_q),
    .wdata_i ({di_re_i, di_im_i}),
    .re_i    (rd_issue),
    .rbank_i (rbank_q),
    .raddr_i (bitrev5(rcnt_q)),
    .rdata_o (rdata)
  );

  assign rd_re = rdata[2*WIDTH-1:WIDTH];
  assign rd_im = rdata[WIDTH-1:0];

`ifdef BITREV_FEEDER_CONJ_EN
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MaxVal = {1'b0, {(WIDTH-1){1'b1}}};
  assign im_out = (rd_im == MinVal) ? MaxVal : ('0 - rd_im);
`else
  assign im_out = rd_im;
`endif

  // Outputs forced to zero while idle and throughout reset.
  assign out_vld    = en_q && !rst;
  assign do_en_o    = out_vld;
  assign do_re_o    = out_vld ? rd_re : '0;
  assign do_im_o    = out_vld ? im_out : '0;
  assign do_first_o = out_vld && first_q;
  assign do_last_o  = out_vld && last_q;

endmodule

// File: tb/tb_bitrev_feeder32.sv
// Randomized bench for bitrev_feeder32 against a frame-level reorder model.
module tb_bitrev_feeder32;
  import fft_pkg::*;

  localparam int W = FFT_WIDTH;
  localparam logic [W-1:0] MinV = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MaxV = {1'b0, {(W-1){1'b1}}};

  logic clk = 1'b0;
  logic rst, di_valid, di_ready, fft_rdy, do_en, do_first, do_last;
  logic [W-1:0] di_re, di_im, do_re, do_im;

  typedef struct {cplx_t d; bit first; bit last;} exp_t;
  typedef struct {cplx_t d; bit first; bit last; int cyc;} obs_t;

  cplx_t cur_q[$];
  exp_t  exp_q[$];
  obs_t  obs_q[$];
  bit    rdy_h[int];
  int    cyc_n = 0;
  int    last_xfer_cyc = 0;
  bit    last_rdy;
  int    n_vec = 0;
  int    n_mis = 0;

  bitrev_feeder32 #(.WIDTH(W), .N(FFT_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .di_re_i    (di_re),
    .di_im_i    (di_im),
    .di_valid_i (di_valid),
    .di_ready_o (di_ready),
    .fft_rdy_i  (fft_rdy),
    .do_re_o    (do_re),
    .do_im_o    (do_im),
    .do_en_o    (do_en),
    .do_first_o (do_first),
    .do_last_o  (do_last)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reverse the 5 binary digits of i by repeated division.
  function automatic int rev(input int i);
    int r = 0;
    int t = i;
    for (int b = 0; b < 5; b++) begin
      r = r * 2 + (t % 2);
      t = t / 2;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] exp_im(input logic [W-1:0] v);
`ifdef BITREV_FEEDER_CONJ_EN
    if (v == MinV) return MaxV;
    return '0 - v;
`else
    return v;
`endif
  endfunction

  // One clock: sample ready, model the transfer, then observe outputs at the negedge.
  task automatic cyc();
    bit xfer;
    #1;
    last_rdy = di_ready;
    rdy_h[cyc_n] = di_ready;
    xfer = di_valid && di_ready;
    if (rst) begin
      cur_q.delete();
      exp_q.delete();
    end
    @(posedge clk);
    if (xfer) begin
      cplx_t s;
      s.re = di_re;
      s.im = di_im;
      cur_q.push_back(s);
      last_xfer_cyc = cyc_n;
      if (cur_q.size() == 32) begin
        for (int i = 0; i < 32; i++) begin
          exp_t e;
          e.d.re  = cur_q[rev(i)].re;
          e.d.im  = exp_im(cur_q[rev(i)].im);
          e.first = (i == 0);
          e.last  = (i == 31);
          exp_q.push_back(e);
        end
        cur_q.delete();
      end
    end
    cyc_n++;
    @(negedge clk);
    if (do_en) begin
      obs_t o;
      o.d.re = do_re;
      o.d.im = do_im;
      o.first = do_first;
      o.last = do_last;
      o.cyc = cyc_n;
      obs_q.push_back(o);
    end
  endtask

  task automatic wait_obs(input int cnt, input int budget, output bit ok);
    int n = 0;
    di_valid = 1'b0;
    while (obs_q.size() < cnt && n < budget) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 3; i++) cyc();
    ok = (obs_q.size() >= cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; di_valid = 1'b0; fft_rdy = 1'b0; di_re = '0; di_im = '0;
    cyc();
    cyc();
    n_vec++;
    if ({do_en, do_first, do_last, di_ready} !== 4'b0 || do_re !== '0 || do_im !== '0) begin
      n_mis++;
      $display("FAIL reset_outputs: got en=%b f=%b l=%b rdy=%b re=%0h im=%0h, want all 0",
               do_en, do_first, do_last, di_ready, do_re, do_im);
    end
    rst = 1'b0;
    cyc();
    n_vec++;
    if (last_rdy !== 1'b1) begin
      n_mis++;
      $display("FAIL reset_ready_after: got %b, want 1", last_rdy);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL reset_no_output: got %0d outputs, want 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  task automatic test_single_frame();
    bit ok;
    int k;
    fft_rdy = 1'b1;
    for (int n = 0; n < 32; n++) begin
      di_valid = 1'b1; di_re = W'(n); di_im = W'(-n);
      cyc();
    end
    k = last_xfer_cyc;
    wait_obs(32, 80, ok);
    n_vec++;
    if (!ok || obs_q.size() != 32) begin
      n_mis++;
      $display("FAIL single_count: got %0d outputs, want 32", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0].cyc != k + 2) begin
        n_mis++;
        $display("FAIL single_latency: got cycle %0d, want %0d", obs_q[0].cyc, k + 2);
      end
      for (int i = 0; i < 32; i++) begin
        logic [W-1:0] want_re, want_im;
        want_re = W'(rev(i));
`ifdef BITREV_FEEDER_CONJ_EN
        want_im = want_re;
`else
        want_im = '0 - want_re;
`endif
        n_vec++;
        if (obs_q[i].d.re !== want_re || obs_q[i].d.im !== want_im ||
            obs_q[i].first !== (i == 0) || obs_q[i].last !== (i == 31)) begin
          n_mis++;
          $display("FAIL single_seq[%0d]: got re=%0d im=%0d f=%b l=%b, want re=%0d im=%0d f=%b l=%b",
                   i, obs_q[i].d.re, obs_q[i].d.im, obs_q[i].first, obs_q[i].last,
                   $signed(want_re), $signed(want_im), (i == 0), (i == 31));
        end
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int drops = 0;
    int gaps = 0;
    int badf = 0;
    fft_rdy = 1'b1;
    for (int n = 0; n < 96; n++) begin
      di_valid = 1'b1; di_re = W'($urandom); di_im = W'($urandom);
      cyc();
      if (!last_rdy) drops++;
    end
    wait_obs(96, 100, ok);
    n_vec++;
    if (drops != 0) begin
      n_mis++;
      $display("FAIL b2b_ready_drop: got %0d drops, want 0", drops);
    end
    n_vec++;
    if (!ok || obs_q.size() != 96) begin
      n_mis++;
      $display("FAIL b2b_count: got %0d outputs, want 96", obs_q.size());
    end
    for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gaps++;
    foreach (obs_q[i]) if (obs_q[i].first != (i % 32 == 0)) badf++;
    n_vec++;
    if (gaps != 0 || badf != 0) begin
      n_mis++;
      $display("FAIL b2b_contiguity: got %0d gaps %0d bad firsts, want 0 0", gaps, badf);
    end
    foreach (obs_q[i]) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL b2b_extra[%0d]: got re=%0d, want no output", i, obs_q[i].d.re);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[i].d !== e.d || obs_q[i].first !== e.first || obs_q[i].last !== e.last) begin
          n_mis++;
          $display("FAIL b2b_data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d",
                   i, obs_q[i].d.re, obs_q[i].d.im, e.d.re, e.d.im);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_stall();
    bit ok;
    int nx = 0;
    int c64 = 0;
    int gaps = 0;
    int c;
    fft_rdy = 1'b0;
    for (int n = 0; n < 70; n++) begin
      di_valid = 1'b1; di_re = W'($urandom); di_im = W'($urandom);
      cyc();
      if (last_rdy) begin
        nx++;
        if (nx == 64) c64 = cyc_n - 1;
      end
    end
    n_vec++;
    if (nx != 64 || last_rdy !== 1'b0 || rdy_h[c64 + 1] !== 1'b0) begin
      n_mis++;
      $display("FAIL stall_fill: got %0d transfers rdy=%b, want 64 rdy=0", nx, last_rdy);
    end
    n_vec++;
    if (obs_q.size() != 0) begin
      n_mis++;
      $display("FAIL stall_no_output: got %0d outputs, want 0", obs_q.size());
    end
    fft_rdy = 1'b1;
    wait_obs(64, 100, ok);
    n_vec++;
    if (!ok || obs_q.size() != 64) begin
      n_mis++;
      $display("FAIL stall_count: got %0d outputs, want 64", obs_q.size());
    end else begin
      for (int i = 1; i < 64; i++) if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gaps++;
      n_vec++;
      if (gaps != 0) begin
        n_mis++;
        $display("FAIL stall_gap: got %0d gaps, want 0", gaps);
      end
      c = obs_q[31].cyc;
      n_vec++;
      if (obs_q[31].last !== 1'b1 || rdy_h[c] !== 1'b1 || rdy_h[c-1] !== 1'b0) begin
        n_mis++;
        $display("FAIL stall_ready_rise: got last=%b rdy=%b,%b, want 1 rdy=0,1",
                 obs_q[31].last, rdy_h[c-1], rdy_h[c]);
      end
    end
    foreach (obs_q[i]) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL stall_extra[%0d]: got re=%0d, want no output", i, obs_q[i].d.re);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[i].d !== e.d || obs_q[i].first !== e.first || obs_q[i].last !== e.last) begin
          n_mis++;
          $display("FAIL stall_data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d",
                   i, obs_q[i].d.re, obs_q[i].d.im, e.d.re, e.d.im);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_midframe();
    bit ok;
    fft_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      di_valid = 1'b1; di_re = W'($urandom); di_im = W'($urandom);
      cyc();
    end
    di_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int n = 0; n < 32; n++) begin
      di_valid = 1'b1; di_re = W'(100 + n); di_im = W'($urandom);
      cyc();
    end
    wait_obs(32, 80, ok);
    n_vec++;
    if (!ok || obs_q.size() != 32) begin
      n_mis++;
      $display("FAIL rstmid_count: got %0d outputs, want 32", obs_q.size());
    end else begin
      n_vec++;
      if (obs_q[0].d.re !== 18'sd100 || obs_q[1].d.re !== 18'sd116 ||
          obs_q[31].d.re !== 18'sd131) begin
        n_mis++;
        $display("FAIL rstmid_restart: got re=%0d,%0d,%0d, want 100,116,131",
                 obs_q[0].d.re, obs_q[1].d.re, obs_q[31].d.re);
      end
    end
    foreach (obs_q[i]) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL rstmid_extra[%0d]: got re=%0d, want no output", i, obs_q[i].d.re);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[i].d !== e.d || obs_q[i].first !== e.first || obs_q[i].last !== e.last) begin
          n_mis++;
          $display("FAIL rstmid_data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d",
                   i, obs_q[i].d.re, obs_q[i].d.im, e.d.re, e.d.im);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_fft_rdy_toggle();
    int n = 0;
    int gaps = 0;
    fft_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      di_valid = 1'b1; di_re = W'($urandom); di_im = W'($urandom);
      cyc();
    end
    di_valid = 1'b0;
    while (obs_q.size() == 0 && n < 10) begin
      cyc();
      n++;
    end
    for (int i = 0; i < 40; i++) begin
      fft_rdy = 1'($urandom_range(0, 1));
      cyc();
    end
    fft_rdy = 1'b1;
    n_vec++;
    if (obs_q.size() != 32) begin
      n_mis++;
      $display("FAIL toggle_count: got %0d outputs, want 32", obs_q.size());
    end
    for (int i = 1; i < obs_q.size(); i++) if (obs_q[i].cyc != obs_q[i-1].cyc + 1) gaps++;
    n_vec++;
    if (gaps != 0) begin
      n_mis++;
      $display("FAIL toggle_gap: got %0d gaps, want 0", gaps);
    end
    foreach (obs_q[i]) begin
      exp_t e;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL toggle_extra[%0d]: got re=%0d, want no output", i, obs_q[i].d.re);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[i].d !== e.d || obs_q[i].first !== e.first || obs_q[i].last !== e.last) begin
          n_mis++;
          $display("FAIL toggle_data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d",
                   i, obs_q[i].d.re, obs_q[i].d.im, e.d.re, e.d.im);
        end
      end
    end
    obs_q.delete();
  endtask

  task automatic test_conj_boundary();
    bit ok;
    logic [W-1:0] want;
`ifdef BITREV_FEEDER_CONJ_EN
    want = 18'h1FFFF;
`else
    want = 18'h20000;
`endif
    fft_rdy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      di_valid = 1'b1; di_re = W'(i);
      di_im = (i % 2 == 0) ? MinV : W'($urandom);
      cyc();
    end
    wait_obs(32, 80, ok);
    n_vec++;
    if (!ok || obs_q.size() != 32) begin
      n_mis++;
      $display("FAIL conj_count: got %0d outputs, want 32", obs_q.size());
    end
    foreach (obs_q[i]) begin
      exp_t e;
      if (obs_q[i].d.re[0] == 1'b0) begin
        n_vec++;
        if (obs_q[i].d.im !== want) begin
          n_mis++;
          $display("FAIL conj_min[%0d]: got im=%0d, want %0d", i, obs_q[i].d.im, $signed(want));
        end
      end
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL conj_extra[%0d]: got re=%0d, want no output", i, obs_q[i].d.re);
      end else begin
        e = exp_q.pop_front();
        if (obs_q[i].d !== e.d || obs_q[i].first !== e.first || obs_q[i].last !== e.last) begin
          n_mis++;
          $display("FAIL conj_data[%0d]: got re=%0d im=%0d, want re=%0d im=%0d",
                   i, obs_q[i].d.re, obs_q[i].d.im, e.d.re, e.d.im);
        end
      end
    end
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_stall();
    test_reset_midframe();
    test_fft_rdy_toggle();
    test_conj_boundary();
    n_vec++;
    if (exp_q.size() != 0 || cur_q.size() != 0) begin
      n_mis++;
      $display("FAIL leftover: got %0d pending outputs %0d partial samples, want 0 0",
               exp_q.size(), cur_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
